// File: rtl/onchip_mem_tester_if.sv
// Memory-side bus of the on-chip memory tester: one access per cycle while chipselect is high,
// read data returns exactly one cycle after a read is issued.
interface onchip_mem_tester_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m_address;
  logic                m_chipselect;
  logic                m_write;
  logic [DATA_W/8-1:0] m_byteenable;
  logic [DATA_W-1:0]   m_writedata;
  logic                m_clken;
  logic [DATA_W-1:0]   m_readdata;

  modport master (
    output m_address,
    output m_chipselect,
    output m_write,
    output m_byteenable,
    output m_writedata,
    output m_clken,
    input  m_readdata
  );

  modport slave (
    input  m_address,
    input  m_chipselect,
    input  m_write,
    input  m_byteenable,
    input  m_writedata,
    input  m_clken,
    output m_readdata
  );
endinterface

// File: rtl/onchip_mem_tester.sv
// Fill/verify tester: writes seed^addr over a window, reads it back, counts mismatches.
// Start-to-done is 2N+2 cycles (1 for an empty window); no backpressure, one access per cycle.
module onchip_mem_tester #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 7741
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_words,
  input  logic [DATA_W-1:0]   seed,
  onchip_mem_tester_if.master mem,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL   = 3'd1,
    S_READ   = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   first_err_q;
  logic [DATA_W-1:0]   seed_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W:0]     n_q;
  logic [ADDR_W:0]     cnt_q;
  logic                cs_q;
  logic                wr_q;
  logic                rd_pend_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [15:0]         err_q;

  logic [ADDR_W:0]     base_ext;
  logic [ADDR_W:0]     avail;
  logic [ADDR_W:0]     n_d;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   exp_rd;
  logic                mismatch;
  logic [15:0]         err_d;
  logic [ADDR_W-1:0]   first_err_d;

  // Effective count is clipped to the implemented words at and above base_addr.
  always_comb begin
    base_ext = {1'b0, base_addr};
    avail    = DEPTH_L - base_ext;
    n_d      = '0;
    if (base_ext < DEPTH_L) begin
      n_d = (num_words < avail) ? num_words : avail;
    end
  end

  // rd_pend_q/rd_addr_q describe the read issued last cycle, whose data is on m_readdata now.
  always_comb begin
    addr_nxt    = addr_q + ADDR_W'(1);
    exp_rd      = seed_q ^ DATA_W'(rd_addr_q);
    mismatch    = rd_pend_q && (mem.m_readdata != exp_rd);
    err_d       = err_q;
    first_err_d = first_err_q;
    if (mismatch) begin
      if (err_q != 16'hFFFF) begin
        err_d = err_q + 16'd1;
      end
      if (err_q == 16'd0) begin
        first_err_d = rd_addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      first_err_q <= '0;
      seed_q      <= '0;
      wdata_q     <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
    end else if (abort && (state_q != S_IDLE)) begin
      state_q   <= S_IDLE;
      cs_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      rd_pend_q <= cs_q && !wr_q;
      rd_addr_q <= addr_q;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            base_q      <= base_addr;
            seed_q      <= seed;
            n_q         <= n_d;
            cnt_q       <= n_d;
            err_q       <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            if (n_d == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= S_FILL;
              cs_q    <= 1'b1;
              wr_q    <= 1'b1;
              addr_q  <= base_addr;
              wdata_q <= seed ^ DATA_W'(base_addr);
            end
          end
        end
        S_FILL: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= S_READ;
            wr_q    <= 1'b0;
            addr_q  <= base_q;
            cnt_q   <= n_q;
          end else begin
            addr_q  <= addr_nxt;
            wdata_q <= seed_q ^ DATA_W'(addr_nxt);
            cnt_q   <= cnt_q - CNT_ONE;
          end
        end
        S_READ: begin
          err_q       <= err_d;
          first_err_q <= first_err_d;
          if (cnt_q == CNT_ONE) begin
            state_q <= S_DRAIN;
            cs_q    <= 1'b0;
          end else begin
            addr_q <= addr_nxt;
            cnt_q  <= cnt_q - CNT_ONE;
          end
        end
        S_DRAIN: begin
          err_q       <= err_d;
          first_err_q <= first_err_d;
          state_q     <= S_FINISH;
          done_q      <= 1'b1;
          pass_q      <= (err_d == 16'd0);
        end
        S_FINISH: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cs_q    <= 1'b0;
          wr_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.m_address    = addr_q;
  assign mem.m_chipselect = cs_q;
  assign mem.m_write      = wr_q;
  assign mem.m_byteenable = {(DATA_W/8){cs_q}};
  assign mem.m_writedata  = wdata_q;
  assign mem.m_clken      = 1'b1;

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_onchip_mem_tester.sv
// Directed bench for onchip_mem_tester with a one-cycle-latency memory model that can corrupt words 5 and 9.
module tb_onchip_mem_tester;
  localparam int AW    = 13;
  localparam int DW    = 32;
  localparam int DEPTH = 7741;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic [DW-1:0] seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  onchip_mem_tester_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  onchip_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .seed           (seed),
    .mem            (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model_mem [0:DEPTH-1];
  logic          corrupt;
  logic          mon_clr;
  int            wr_cnt;
  int            rd_cnt;
  int            done_cnt;
  logic [AW-1:0] wr_last;

  always @(posedge clk) begin
    if (bus.m_chipselect && bus.m_write) model_mem[bus.m_address] <= bus.m_writedata;
    if (bus.m_chipselect && !bus.m_write)
      bus.m_readdata <= model_mem[bus.m_address] ^
                        {31'b0, corrupt && (bus.m_address == 13'd5 || bus.m_address == 13'd9)};
  end

  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt   <= 0;
      rd_cnt   <= 0;
      done_cnt <= 0;
      wr_last  <= '0;
    end else begin
      if (bus.m_chipselect && bus.m_write) begin
        wr_cnt  <= wr_cnt + 1;
        wr_last <= bus.m_address;
      end
      if (bus.m_chipselect && !bus.m_write) rd_cnt <= rd_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives start for cycle 0; returns just after the edge that samples it (cycle 1).
  task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n, input logic [DW-1:0] s);
    base_addr = b;
    num_words = n;
    seed      = s;
    start     = 1'b1;
    mon_clr   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    mon_clr = 1'b0;
  endtask

  // Returns the cycle done is seen in (-1 on timeout), leaving time just after the following edge.
  task automatic wait_done(input int c0, output int lat);
    lat = -1;
    for (int c = c0; c < c0 + 200; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_pass"}, pass, 0);
    check_eq({tag, "_err"}, err_count, 0);
    check_eq({tag, "_ferr"}, first_err_addr, 0);
    check_eq({tag, "_cs"}, bus.m_chipselect, 0);
    check_eq({tag, "_wr"}, bus.m_write, 0);
    check_eq({tag, "_addr"}, bus.m_address, 0);
    check_eq({tag, "_wdata"}, bus.m_writedata, 0);
    check_eq({tag, "_be"}, bus.m_byteenable, 0);
  endtask

  int lat;
  int reads;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    corrupt   = 1'b0;
    mon_clr   = 1'b1;
    base_addr = '0;
    num_words = '0;
    seed      = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    check_eq("clken", bus.m_clken, 1);
    reset   = 1'b0;
    mon_clr = 1'b0;
    @(posedge clk); #1;

    // Clean 16-word pass.
    launch(13'd0, 14'd16, 32'hA5A5A5A5);
    check_eq("p1_busy", busy, 1);
    check_eq("p1_be", bus.m_byteenable, 4'hF);
    check_eq("p1_wdata0", bus.m_writedata, 32'hA5A5A5A5);
    wait_done(1, lat);
    check_eq("p1_lat", lat, 34);
    check_eq("p1_wr", wr_cnt, 16);
    check_eq("p1_rd", rd_cnt, 16);
    check_eq("p1_done_cnt", done_cnt, 1);
    check_eq("p1_pass", pass, 1);
    check_eq("p1_err", err_count, 0);
    check_eq("p1_mem5", model_mem[5], 32'hA5A5A5A0);
    check_eq("p1_busy_end", busy, 0);

    // Words 5 and 9 read back with bit 0 flipped.
    corrupt = 1'b1;
    launch(13'd0, 14'd16, 32'hA5A5A5A5);
    wait_done(1, lat);
    corrupt = 1'b0;
    check_eq("p2_lat", lat, 34);
    check_eq("p2_err", err_count, 2);
    check_eq("p2_ferr", first_err_addr, 5);
    check_eq("p2_pass", pass, 0);

    // Window starting past the last word: empty pass.
    launch(13'd7741, 14'd100, 32'h0);
    wait_done(1, lat);
    check_eq("p3_lat", lat, 1);
    check_eq("p3_pass", pass, 1);
    check_eq("p3_wr", wr_cnt, 0);
    check_eq("p3_rd", rd_cnt, 0);

    // Window clipped to the single last word.
    launch(13'd7740, 14'd10, 32'h12340000);
    wait_done(1, lat);
    check_eq("p4_lat", lat, 4);
    check_eq("p4_wr", wr_cnt, 1);
    check_eq("p4_rd", rd_cnt, 1);
    check_eq("p4_wr_last", wr_last, 13'd7740);
    check_eq("p4_mem", model_mem[7740], 32'h12341E3C);
    check_eq("p4_pass", pass, 1);

    // Abort after the third read.
    launch(13'd0, 14'd16, 32'h0);
    reads = 0;
    for (int c = 0; c < 100 && reads < 3; c++) begin
      @(negedge clk);
      if (bus.m_chipselect && !bus.m_write) reads++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("ab_reads", reads, 3);
    check_eq("ab_cs", bus.m_chipselect, 0);
    check_eq("ab_busy", busy, 0);
    check_eq("ab_done", done, 0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("ab_done_cnt", done_cnt, 0);
    check_eq("ab_rd", rd_cnt, 3);
    check_eq("ab_pass", pass, 0);
    check_eq("ab_err", err_count, 0);

    // Start together with abort in IDLE is ignored.
    base_addr = 13'd0;
    num_words = 14'd16;
    start     = 1'b1;
    abort     = 1'b1;
    mon_clr   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    abort   = 1'b0;
    mon_clr = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("sa_busy", busy, 0);
    check_eq("sa_wr", wr_cnt, 0);
    check_eq("sa_done_cnt", done_cnt, 0);

    // Reset in the middle of FILL, then a full pass.
    launch(13'd0, 14'd16, 32'hA5A5A5A5);
    repeat (4) @(posedge clk);
    #1;
    check_eq("mr_addr_mid", bus.m_address, 4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("mr");
    launch(13'd0, 14'd16, 32'hA5A5A5A5);
    wait_done(1, lat);
    check_eq("mr_lat", lat, 34);
    check_eq("mr_wr", wr_cnt, 16);
    check_eq("mr_pass", pass, 1);

    // Start re-pulsed with a different base during FILL.
    launch(13'd0, 14'd16, 32'h0F0F0000);
    repeat (4) @(posedge clk);
    #1;
    base_addr = 13'd50;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, lat);
    check_eq("rp_lat", lat, 34);
    check_eq("rp_wr", wr_cnt, 16);
    check_eq("rp_rd", rd_cnt, 16);
    check_eq("rp_wr_last", wr_last, 15);
    check_eq("rp_done_cnt", done_cnt, 1);
    check_eq("rp_pass", pass, 1);
    check_eq("rp_mem15", model_mem[15], 32'h0F0F000F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
